// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: serialises CPU load/store and external accesses onto one RAM port.
// Build option ARB_CPU_PRIORITY_EN: fixed CPU priority on ties instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  logic [1:0]    state, state_d;
  logic          owner, owner_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          mem_re_d, mem_we_d, ext_gnt_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, cpu_rdata_d, ext_rdata_d;
  logic          cpu_req;
  logic          win;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign cpu_stall = cpu_req & ~((state == S_DONE) & (owner == OWN_CPU));

`ifdef ARB_CPU_PRIORITY_EN
  assign win = cpu_req ? OWN_CPU : OWN_EXT;
`else
  logic last_winner, last_winner_d;

  // The CPU loses a tie only when it was the most recent winner.
  assign win = (cpu_req & (~ext_req | (last_winner == OWN_EXT))) ? OWN_CPU : OWN_EXT;
`endif

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    cnt_d       = cnt;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    ext_gnt_d   = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_rdata_d = cpu_rdata;
    ext_rdata_d = ext_rdata;
`ifndef ARB_CPU_PRIORITY_EN
    last_winner_d = last_winner;
`endif
    case (state)
      S_IDLE: begin
        if (cpu_req | ext_req) begin
          owner_d     = win;
          mem_we_d    = (win == OWN_CPU) ? cpu_wr : ext_we;
          mem_re_d    = ~mem_we_d;
          mem_addr_d  = (win == OWN_CPU) ? cpu_addr : ext_addr;
          mem_wdata_d = (win == OWN_CPU) ? cpu_wdata : ext_wdata;
          state_d     = S_ACC;
`ifndef ARB_CPU_PRIORITY_EN
          last_winner_d = win;
`endif
        end
      end
      S_ACC: begin
        if (mem_we) begin
          state_d   = S_DONE;
          ext_gnt_d = (owner == OWN_EXT);
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          if (owner == OWN_CPU) cpu_rdata_d = mem_rdata;
          else                  ext_rdata_d = mem_rdata;
          state_d   = S_DONE;
          ext_gnt_d = (owner == OWN_EXT);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      // No grant here: the CPU still holds the request it is about to commit.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= OWN_CPU;
      cnt       <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      ext_gnt   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
`ifndef ARB_CPU_PRIORITY_EN
      last_winner <= OWN_EXT;
`endif
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      cnt       <= cnt_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      ext_gnt   <= ext_gnt_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_rdata <= cpu_rdata_d;
      ext_rdata <= ext_rdata_d;
`ifndef ARB_CPU_PRIORITY_EN
      last_winner <= last_winner_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus random CPU/ext traffic against a service-order model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  logic rst, rst3;
  always #5 clk = ~clk;

  logic          cpu_rd, cpu_wr, cpu_stall, ext_req, ext_we, ext_gnt, mem_re, mem_we;
  logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ext_wdata, ext_rdata, mem_wdata, mem_rdata;

  logic          d3_cpu_rd, d3_cpu_wr, d3_cpu_stall, d3_ext_req, d3_ext_we, d3_ext_gnt, d3_mem_re, d3_mem_we;
  logic [AW-1:0] d3_cpu_addr, d3_ext_addr, d3_mem_addr;
  logic [DW-1:0] d3_cpu_wdata, d3_cpu_rdata, d3_ext_wdata, d3_ext_rdata, d3_mem_wdata, d3_mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .cpu_rd(d3_cpu_rd), .cpu_wr(d3_cpu_wr), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
    .cpu_rdata(d3_cpu_rdata), .cpu_stall(d3_cpu_stall),
    .ext_req(d3_ext_req), .ext_we(d3_ext_we), .ext_addr(d3_ext_addr), .ext_wdata(d3_ext_wdata),
    .ext_gnt(d3_ext_gnt), .ext_rdata(d3_ext_rdata),
    .mem_re(d3_mem_re), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(d3_mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  int unsigned tick = 0;
  int order_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) tick <= tick + 1;

  // RAM models; unread cycles return a tick-stamped junk word so mistimed sampling shows.
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram  [256];
  logic [31:0] ram3 [256];
  logic [31:0] ref_mem [256];
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_re ? ram[mem_addr[7:0]] : {16'hBAD0, tick[15:0]};
  end

  always @(posedge clk) begin
    if (pre_we) ram3[pre_addr] <= pre_data;
    else if (d3_mem_we) ram3[d3_mem_addr[7:0]] <= d3_mem_wdata;
    p3[0] <= d3_mem_re ? ram3[d3_mem_addr[7:0]] : {16'hBAD3, tick[15:0]};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign d3_mem_rdata = p3[2];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output int stalls, output int re_n, output int we_n);
    @(posedge clk); #1;
    cpu_rd = ~we; cpu_wr = we; cpu_addr = 32'(a); cpu_wdata = d;
    stalls = 0; re_n = 0; we_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) we_n++;
      if (!cpu_stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic ext_op(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output int cycles, output int gnt_n, output int stall_seen);
    @(posedge clk); #1;
    ext_req = 1'b1; ext_we = we; ext_addr = 32'(a); ext_wdata = d;
    cycles = 0; gnt_n = 0; stall_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cpu_stall) stall_seen = 1;
      if (ext_gnt) begin gnt_n++; break; end
      cycles++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ext_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ext_gnt) gnt_n++;
      if (cpu_stall) stall_seen = 1;
    end
  endtask

  // Service model: one access at a time; a write holds the port 3 cycles, a read 3+MEM_LAT,
  // and a new grant is taken on the cycle after the previous completion.
  task automatic run_traffic(input bit scripted, input int ncyc);
    bit cb, eb, cg, eg, cwe, ewe, cboth, win_ext, last_ext, s_we, c_commit, e_commit, pc, pe;
    logic [7:0]  caddr, eaddr, s_addr;
    logic [31:0] cdata, edata, s_data, exp_crd, exp_erd;
    int c_done, e_done, srv_free, s_cyc, c_idle, e_idle, c_ops, e_ops, dur, c;
    cb = 0; eb = 0; cg = 0; eg = 0; cwe = 0; ewe = 0; cboth = 0; last_ext = 1; s_we = 0;
    caddr = 0; eaddr = 0; s_addr = 0; cdata = 0; edata = 0; s_data = 0;
    exp_crd = 0; exp_erd = 0; c_done = -1; e_done = -1; srv_free = 0; s_cyc = -1;
    c_idle = 0; e_idle = 0; c_ops = scripted ? 2 : 1 << 30; e_ops = c_ops; c = 0;
    order_q.delete();
    while ((c < ncyc || cb || eb) && c < ncyc + 200) begin
      if (!cb && c < ncyc) begin
        if (c_idle > 0) c_idle--;
        else if (c_ops > 0) begin
          cb = 1; cg = 0; c_ops--;
          cwe = scripted ? 1'b0 : 1'($urandom_range(0, 1));
          cboth = !scripted && ($urandom_range(0, 3) == 0);
          caddr = scripted ? 8'h10 : 8'($urandom);
          cdata = $urandom;
        end
      end
      if (!eb && c < ncyc) begin
        if (e_idle > 0) e_idle--;
        else if (e_ops > 0) begin
          eb = 1; eg = 0; e_ops--;
          ewe = scripted ? 1'b0 : 1'($urandom_range(0, 1));
          eaddr = scripted ? 8'h40 : 8'($urandom);
          edata = $urandom;
        end
      end
      @(posedge clk); #1;
      cpu_rd = cb && (!cwe || cboth); cpu_wr = cb && cwe;
      cpu_addr = 32'(caddr); cpu_wdata = cdata;
      ext_req = eb; ext_we = ewe; ext_addr = 32'(eaddr); ext_wdata = edata;
      @(negedge clk);
      if (c >= srv_free) begin
        pc = cb && !cg;
        pe = eb && !eg;
        if (pc || pe) begin
`ifdef ARB_CPU_PRIORITY_EN
          win_ext = !pc;
`else
          win_ext = (pc && pe) ? !last_ext : pe;
`endif
          last_ext = win_ext;
          s_we   = win_ext ? ewe : cwe;
          s_addr = win_ext ? eaddr : caddr;
          s_data = win_ext ? edata : cdata;
          dur    = s_we ? 2 : 2 + int'(LAT);
          if (win_ext) begin eg = 1; e_done = c + dur; end
          else begin cg = 1; c_done = c + dur; end
          srv_free = c + dur + 1;
          s_cyc = c + 1;
        end
      end
      c_commit = cb && cg && (c_done == c);
      e_commit = eb && eg && (e_done == c);
      if (c_commit && !cwe) exp_crd = ref_mem[caddr];
      if (e_commit && !ewe) exp_erd = ref_mem[eaddr];
      check("cpu_stall", cpu_stall, cb && !c_commit);
      check("ext_gnt", ext_gnt, e_commit);
      check("mem_re", mem_re, (s_cyc == c) && !s_we);
      check("mem_we", mem_we, (s_cyc == c) && s_we);
      if (s_cyc == c) begin
        check("mem_addr", mem_addr, 32'(s_addr));
        if (s_we) check("mem_wdata", mem_wdata, s_data);
      end
      check("cpu_rdata", cpu_rdata, exp_crd);
      check("ext_rdata", ext_rdata, exp_erd);
      if (c_commit) begin
        if (cwe) ref_mem[caddr] = cdata;
        cb = 0; order_q.push_back(0);
        c_idle = scripted ? 0 : $urandom_range(0, 3);
      end
      if (e_commit) begin
        if (ewe) ref_mem[eaddr] = edata;
        eb = 0; order_q.push_back(1);
        e_idle = scripted ? 0 : $urandom_range(0, 4);
      end
      c++;
    end
    check("traffic_drained", {62'd0, cb, eb}, 64'd0);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; ext_req = 1'b0;
  endtask

  initial begin
    int st, rn, wn, cyc, gn, ss;
    int exp_order[4];
    rst = 1'b1; rst3 = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    d3_cpu_rd = 0; d3_cpu_wr = 0; d3_cpu_addr = 0; d3_cpu_wdata = 0;
    d3_ext_req = 0; d3_ext_we = 0; d3_ext_addr = 0; d3_ext_wdata = 0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(i);
      pre_data = (i == 16) ? 32'hDEADBEEF : (i == 64) ? 32'h5A5A1234 :
                 (i == 48) ? 32'hCAFEF00D : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;

    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_ext_gnt", ext_gnt, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    rst = 1'b0; rst3 = 1'b0;

    cpu_op(1'b0, 8'h10, 32'h0, st, rn, wn);
    check("t1_stall_cycles", st, 3);
    check("t1_re_pulses", rn, 1);
    check("t1_we_pulses", wn, 0);
    check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    cpu_op(1'b1, 8'h20, 32'h12345678, st, rn, wn);
    ref_mem[8'h20] = 32'h12345678;
    check("t2_stall_cycles", st, 2);
    check("t2_we_pulses", wn, 1);
    check("t2_re_pulses", rn, 0);
    cpu_op(1'b0, 8'h20, 32'h0, st, rn, wn);
    check("t2_readback", cpu_rdata, 32'h12345678);

    ext_op(1'b0, 8'h40, 32'h0, cyc, gn, ss);
    check("t3_cycles_to_gnt", cyc, 3);
    check("t3_gnt_pulses", gn, 1);
    check("t3_ext_rdata", ext_rdata, 32'h5A5A1234);
    check("t3_cpu_stall_seen", ss, 0);
    check("t3_cpu_rdata_held", cpu_rdata, 32'h12345678);

    do_reset();
    run_traffic(1'b1, 40);
`ifdef ARB_CPU_PRIORITY_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    check("t4_order_len", order_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_order_%0d", k), (k < order_q.size()) ? order_q[k] : -1, exp_order[k]);

    do_reset();
    run_traffic(1'b0, 1500);

    // MEM_LAT=3 instance: full load, then reset in the middle of a second load.
    @(posedge clk); #1;
    d3_cpu_rd = 1'b1; d3_cpu_addr = 32'h30;
    st = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!d3_cpu_stall) break;
      st++;
    end
    check("t6_lat3_stall_cycles", st, 5);
    check("t6_lat3_rdata", d3_cpu_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    d3_cpu_rd = 1'b0;
    @(posedge clk); #1;
    d3_cpu_rd = 1'b1; d3_cpu_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    check("t6_acc_mem_re", d3_mem_re, 1);
    @(negedge clk);
    #1 rst3 = 1'b1;
    #1;
    check("t6_rst_mem_re", d3_mem_re, 0);
    check("t6_rst_mem_we", d3_mem_we, 0);
    check("t6_rst_mem_addr", d3_mem_addr, 0);
    check("t6_rst_cpu_rdata", d3_cpu_rdata, 0);
    check("t6_rst_ext_gnt", d3_ext_gnt, 0);
    check("t6_rst_stall_held_req", d3_cpu_stall, 1);
    d3_cpu_rd = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t6_no_stale_rdata", d3_cpu_rdata, 0);
      check("t6_idle_mem_re", d3_mem_re, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
